huff_tree_ctrl: RTL
===================

HUFF_TREE_CTRL -- requirements
Module: huff_tree_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clock port clk, reset port rst_n.
REQ-002 The block SHALL have parameter SUM_MAX, default 30, setting the maximum accepted total input weight (legal range 1..30).
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input weight beat valid
- in_weight  in  5  weight of character n (n = beat index 0..7)
- sort_character  out  32  sort IP character lanes; lane i = bits 4i+3:4i
- sort_weight  out  40  sort IP weight lanes; lane i = bits 5i+4:5i
- sort_out_character  in  32  sorted characters returned by the combinational 8-lane sort IP
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result beat valid
- out_len  out  3  Huffman code length of character n on beat n
- out_err  out  1  total weight exceeded SUM_MAX

Function
REQ-004 The block SHALL use states IDLE, LOAD, CHECK, SORT, MERGE, OUT, ERR.
REQ-005 The sort IP contract SHALL be: lane k of sort_out_character holds the character with the k-th smallest weight, lane 0 smallest, ties kept in input-lane order.
REQ-006 sort_character lane i SHALL be the constant i at all times; sort_weight lane i SHALL be the group weight register gw[i].
REQ-007 In IDLE, a cycle with in_valid=1 SHALL store in_weight as w[0] and move to LOAD; in_valid=0 SHALL keep the block in IDLE.
REQ-008 LOAD SHALL store beats 1..7 only on in_valid=1 cycles; gaps are allowed; after beat 7 the block SHALL go to CHECK.
REQ-009 During load the block SHALL set, per character i: gw[i]=w[i], grp[i]=i, len[i]=0, and accumulate an 8-bit sum.
REQ-010 In CHECK, if sum > SUM_MAX the block SHALL go to ERR; otherwise it SHALL clear the merge counter and go to SORT.
REQ-011 In SORT the block SHALL register a = lane 0 and b = lane 1 of sort_out_character, then go to MERGE.
REQ-012 MERGE SHALL do all of the following in one cycle: gw[a] <= gw[a]+gw[b]; gw[b] <= 31; for every i with grp[i]==a or grp[i]==b, len[i]++; for every i with grp[i]==b, grp[i] <= a; increment the merge counter.
REQ-013 After the 7th MERGE the block SHALL go to OUT; otherwise it SHALL return to SORT.
REQ-014 Weight 31 SHALL mark an inactive lane; merged weights never exceed 30, so inactive lanes always sort last.
REQ-015 OUT SHALL assert out_valid for 8 consecutive cycles with out_len = len[0..7] in order and out_err=0, then go to IDLE.
REQ-016 ERR SHALL assert out_valid and out_err for exactly 1 cycle with out_len=0, then go to IDLE.
REQ-017 Fixed latency SHALL be: first out_valid exactly 16 cycles after the beat-7 cycle (CHECK 1 + 7×2 + 1), or 2 cycles after for ERR.
REQ-018 in_valid SHALL be ignored in CHECK, SORT, MERGE, OUT and ERR; a new frame may start in the cycle after the last OUT or ERR beat.
REQ-019 out_len and out_err SHALL be 0 whenever out_valid=0.

Reset
REQ-020 When rst_n=0 at a clk edge, the block SHALL go to IDLE with busy=0, out_valid=0, out_len=0, out_err=0, all gw=31, grp[i]=i, len=0, sum=0 and counters 0.
REQ-021 Reset SHALL override any state, including mid-LOAD, mid-merge and mid-OUT, and SHALL discard the partial frame.

Verification
REQ-022 Weights 1,1,2,3,4,5,6,7 -> out_len 5,5,4,3,3,3,2,2, out_err=0.
REQ-023 All weights 1 (sum 8) -> every out_len = 3.
REQ-024 All weights 4 (sum 32) -> a single out_valid beat with out_err=1, out_len=0, 2 cycles after beat 7.
REQ-025 Weights 1,1,1,1,1,1,1,23 (sum 30, boundary) -> no error and 8 beats whose lengths satisfy Kraft sum = 1, with char 7 out_len=1.
REQ-026 Load with 3 in_valid gaps -> results identical to the gap-free run, counted from beat 7.
REQ-027 rst_n=0 during the 4th MERGE, then a new frame -> the new frame's results are correct with no carry-over from the aborted frame.

Source files
------------

// File: rtl/huff_tree_ctrl.sv
// Huffman code-length controller: loads 8 weights, repeatedly merges the two
// lightest groups using an external combinational sort IP, then streams lengths.
module huff_tree_ctrl #(
    parameter int unsigned SUM_MAX = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [4:0]  in_weight,
    output logic [31:0] sort_character,
    output logic [39:0] sort_weight,
    input  logic [31:0] sort_out_character,
    output logic        busy,
    output logic        out_valid,
    output logic [2:0]  out_len,
    output logic        out_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        SORT,
        MERGE,
        OUT,
        ERR
    } state_e;

    localparam logic [7:0] SUM_LIMIT = 8'(SUM_MAX);
    localparam logic [4:0] W_INACTIVE = 5'd31;

    state_e     state_q, state_d;
    logic [4:0] gw_q  [8];
    logic [4:0] gw_d  [8];
    logic [2:0] grp_q [8];
    logic [2:0] grp_d [8];
    logic [2:0] len_q [8];
    logic [2:0] len_d [8];
    logic [7:0] sum_q, sum_d;
    // Shared between LOAD (beat index) and OUT (result index); never live together.
    logic [2:0] beat_q, beat_d;
    logic [2:0] merge_q, merge_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;

    // Only the low 3 bits of each of the two lightest lanes are ever needed.
    logic unused_sort_bits;
    assign unused_sort_bits = ^{sort_out_character[31:8], sort_out_character[7],
                                sort_out_character[3]};

    always_comb begin
        sort_character = '0;
        sort_weight    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sort_character[4*i +: 4] = 4'(i);
            sort_weight[5*i +: 5]    = gw_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        gw_d      = gw_q;
        grp_d     = grp_q;
        len_d     = len_q;
        sum_d     = sum_q;
        beat_d    = beat_q;
        merge_d   = merge_q;
        a_d       = a_q;
        b_d       = b_q;
        busy      = (state_q != IDLE);
        out_valid = 1'b0;
        out_len   = '0;
        out_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    gw_d[0] = in_weight;
                    for (int unsigned i = 0; i < 8; i++) begin
                        grp_d[i] = 3'(i);
                        len_d[i] = '0;
                    end
                    sum_d   = {3'b000, in_weight};
                    beat_d  = 3'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    gw_d[beat_q] = in_weight;
                    sum_d        = sum_q + {3'b000, in_weight};
                    beat_d       = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                beat_d = '0;
                if (sum_q > SUM_LIMIT) begin
                    state_d = ERR;
                end else begin
                    merge_d = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                a_d     = sort_out_character[2:0];
                b_d     = sort_out_character[6:4];
                state_d = MERGE;
            end
            MERGE: begin
                gw_d[a_q] = gw_q[a_q] + gw_q[b_q];
                gw_d[b_q] = W_INACTIVE;
                for (int unsigned i = 0; i < 8; i++) begin
                    if ((grp_q[i] == a_q) || (grp_q[i] == b_q)) begin
                        len_d[i] = len_q[i] + 3'd1;
                    end
                    if (grp_q[i] == b_q) begin
                        grp_d[i] = a_q;
                    end
                end
                merge_d = merge_q + 3'd1;
                state_d = (merge_q == 3'd6) ? OUT : SORT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_len   = len_q[beat_q];
                beat_d    = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                out_valid = 1'b1;
                out_err   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i < 8; i++) begin
                gw_q[i]  <= W_INACTIVE;
                grp_q[i] <= 3'(i);
                len_q[i] <= '0;
            end
            sum_q   <= '0;
            beat_q  <= '0;
            merge_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            gw_q    <= gw_d;
            grp_q   <= grp_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            beat_q  <= beat_d;
            merge_q <= merge_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule
